// File: rtl/fir_ctrl_pkg.sv
// Shared types and defaults for the single-MAC FIR sequencer.
package fir_ctrl_pkg;

    localparam int unsigned FIR_SIZE_DEF = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fir_state_t;

endpackage

// File: rtl/tap_counter.sv
// Tap/coefficient index counter with synchronous clear, enable and terminal-count flag.
module tap_counter #(
    parameter int unsigned AddrWidth = 6,
    parameter int unsigned Last      = 63
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    output logic [AddrWidth-1:0] cnt,
    output logic                 tc
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + AddrWidth'(1);
        end
    end

    assign tc = (cnt == AddrWidth'(Last));

endmodule

// File: rtl/fir_mac_controller.sv
// Sequencer for the single-MAC FIR datapath: accepts a sample, sweeps all taps,
// drains the multiplier pipeline and holds the finished sum until the sink takes it.
module fir_mac_controller
    import fir_ctrl_pkg::*;
#(
    parameter int unsigned FIR_size  = FIR_SIZE_DEF,
    parameter int unsigned AddrWidth = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inp_valid,
    output logic                 inp_ready,
    input  logic                 abort,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic                 shift,
    output logic                 flush,
    output logic [AddrWidth-1:0] address,
    output logic                 mult_ld,
    output logic                 acc_ld,
    output logic                 busy
);

    localparam logic [AddrWidth-1:0] LAST_ADDR = AddrWidth'(FIR_size - 1);

    fir_state_t           state;
    fir_state_t           state_nxt;
    logic [AddrWidth-1:0] cnt;
    logic                 cnt_tc;
    logic                 cnt_clr;
    logic                 cnt_en;

    tap_counter #(
        .AddrWidth (AddrWidth),
        .Last      (FIR_size - 1)
    ) u_tap_counter (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .cnt (cnt),
        .tc  (cnt_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and Mealy datapath controls; abort overrides every state.
    always_comb begin
        state_nxt = state;
        inp_ready = 1'b0;
        out_valid = 1'b0;
        shift     = 1'b0;
        flush     = 1'b0;
        address   = '0;
        mult_ld   = 1'b0;
        acc_ld    = 1'b0;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;

        unique case (state)
            IDLE: begin
                inp_ready = 1'b1;
                shift     = inp_valid & rst;
                flush     = inp_valid & rst;
                if (inp_valid) begin
                    state_nxt = MAC;
                    cnt_clr   = 1'b1;
                end
            end
            MAC: begin
                address = cnt;
                mult_ld = 1'b1;
                acc_ld  = 1'b1;
                cnt_en  = 1'b1;
                if (cnt_tc) begin
                    state_nxt = DRAIN;
                    cnt_clr   = 1'b1;
                end
            end
            DRAIN: begin
                address   = LAST_ADDR;
                acc_ld    = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (abort) begin
            state_nxt = IDLE;
            cnt_clr   = 1'b1;
            shift     = 1'b0;
            flush     = rst;
            mult_ld   = 1'b0;
            acc_ld    = 1'b0;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_fir_mac_controller.sv
// Directed bench: drives the controller against a behavioural FIR datapath and checks sums/timing.
module tb_fir_mac_controller;

    logic       clk;
    logic       rst;
    logic       inp_valid;
    logic       inp_ready;
    logic       abort;
    logic       out_ready;
    logic       out_valid;
    logic       shift;
    logic       flush;
    logic [5:0] address;
    logic       mult_ld;
    logic       acc_ld;
    logic       busy;

    logic [15:0] din;
    logic [15:0] xs [64];
    logic [31:0] mp;
    logic [39:0] acc;

    int errors = 0;
    int checks = 0;

    fir_mac_controller #(.FIR_size(64), .AddrWidth(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .inp_valid (inp_valid),
        .inp_ready (inp_ready),
        .abort     (abort),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .shift     (shift),
        .flush     (flush),
        .address   (address),
        .mult_ld   (mult_ld),
        .acc_ld    (acc_ld),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] coeff(input logic [5:0] a);
        return 16'(a) + 16'd1;
    endfunction

    // Behavioural datapath: shift register, multPipe and accumulator driven by the controller.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++) xs[i] <= '0;
            mp  <= '0;
            acc <= '0;
        end else begin
            if (shift) begin
                for (int i = 63; i > 0; i--) xs[i] <= xs[i-1];
                xs[0] <= din;
            end
            if (flush) begin
                mp  <= '0;
                acc <= '0;
            end else begin
                if (mult_ld) mp <= 32'(xs[address]) * 32'(coeff(address));
                if (acc_ld)  acc <= acc + 40'(mp);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int n;
        int bad_addr;
        int exp_idx;
        int bad_flush;
        int drain_addr;
        int cyc;
        int last;
        int shifts;
        int results;
        int ov;
        logic prev_shift;
        logic bump;
        logic [39:0] exp_sum [3];

        exp_sum[0] = 40'd4;
        exp_sum[1] = 40'd10;
        exp_sum[2] = 40'd20;

        rst = 1'b0; inp_valid = 1'b1; abort = 1'b0; out_ready = 1'b0; din = 16'd9;

        // Reset values with a pending sample on the input
        #12;
        check("rst_inp_ready", 64'(inp_ready), 64'd1);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_address",   64'(address),   64'd0);
        check("rst_shift",     64'(shift),     64'd0);
        check("rst_flush",     64'(flush),     64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);

        // Asynchronous reset in the middle of the tap sweep
        @(negedge clk); rst = 1'b1;
        next_cyc();
        inp_valid = 1'b0;
        n = 0;
        while (!(mult_ld && address == 6'd20) && n < 100) begin next_cyc(); n++; end
        check("mid_mac_reached", 64'(address), 64'd20);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_busy",      64'(busy),      64'd0);
        check("mid_rst_address",   64'(address),   64'd0);
        check("mid_rst_inp_ready", 64'(inp_ready), 64'd1);
        next_cyc();
        rst = 1'b1;
        next_cyc();

        // Impulse: latency, address sweep and result
        din = 16'd1; inp_valid = 1'b1;
        #1;
        check("acc_shift", 64'(shift), 64'd1);
        check("acc_flush", 64'(flush), 64'd1);
        next_cyc();
        inp_valid = 1'b0;
        n = 1; bad_addr = 0; exp_idx = 0; bad_flush = 0; drain_addr = -1;
        while (!out_valid && n < 200) begin
            #1;
            if (mult_ld) begin
                if (32'(address) != exp_idx) bad_addr++;
                exp_idx++;
            end
            if (acc_ld && !mult_ld) drain_addr = int'(address);
            if (flush) bad_flush++;
            next_cyc();
            n++;
        end
        check("latency_cycles", 64'(n),          64'd66);
        check("addr_sequence",  64'(bad_addr),   64'd0);
        check("addr_count",     64'(exp_idx),    64'd64);
        check("drain_address",  64'(drain_addr), 64'd63);
        check("no_flush_sweep", 64'(bad_flush),  64'd0);
        check("impulse_dout",   64'(acc),        64'd1);

        // Backpressure in DONE, with a new sample waiting
        inp_valid = 1'b1; din = 16'd7;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_dout",      64'(acc),       64'd1);
            check("bp_inp_ready", 64'(inp_ready), 64'd0);
            check("bp_shift",     64'(shift),     64'd0);
            check("bp_flush",     64'(flush),     64'd0);
            next_cyc();
        end
        inp_valid = 1'b0; out_ready = 1'b1;
        next_cyc();
        check("release_busy",      64'(busy),      64'd0);
        check("release_out_valid", 64'(out_valid), 64'd0);
        check("release_inp_ready", 64'(inp_ready), 64'd1);

        // Back-to-back samples 2,3,4 with inp_valid held
        din = 16'd2; inp_valid = 1'b1;
        cyc = 0; last = 0; shifts = 0; results = 0; prev_shift = 1'b0;
        while (results < 3 && cyc < 400) begin
            #1;
            bump = 1'b0;
            if (prev_shift) check("shift_one_cycle", 64'(shift), 64'd0);
            if (shift) begin
                if (shifts > 0) check("issue_interval", 64'(cyc - last), 64'd67);
                last = cyc;
                shifts++;
                bump = 1'b1;
            end
            if (out_valid) begin
                check("b2b_dout", 64'(acc), 64'(exp_sum[results]));
                results++;
            end
            prev_shift = shift;
            next_cyc();
            cyc++;
            if (bump) begin
                din = din + 16'd1;
                if (shifts == 3) inp_valid = 1'b0;
            end
        end
        check("b2b_results", 64'(results), 64'd3);
        check("b2b_shifts",  64'(shifts),  64'd3);
        next_cyc();
        check("b2b_idle", 64'(busy), 64'd0);

        // Abort at tap 30, then a clean sample
        din = 16'd5; inp_valid = 1'b1;
        next_cyc();
        inp_valid = 1'b0;
        n = 0;
        while (!(mult_ld && address == 6'd30) && n < 100) begin next_cyc(); n++; end
        check("abort_point", 64'(address), 64'd30);
        abort = 1'b1;
        #1;
        check("abort_flush", 64'(flush), 64'd1);
        check("abort_shift", 64'(shift), 64'd0);
        next_cyc();
        abort = 1'b0;
        check("abort_busy",      64'(busy),      64'd0);
        check("abort_inp_ready", 64'(inp_ready), 64'd1);
        ov = 0;
        for (int i = 0; i < 80; i++) begin
            if (out_valid) ov++;
            next_cyc();
        end
        check("abort_no_result", 64'(ov), 64'd0);
        din = 16'd6; inp_valid = 1'b1;
        next_cyc();
        inp_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 200) begin next_cyc(); n++; end
        check("post_abort_valid", 64'(out_valid), 64'd1);
        check("post_abort_dout",  64'(acc),       64'd56);
        next_cyc();
        check("post_abort_idle", 64'(busy), 64'd0);

        // inp_valid together with abort in IDLE
        inp_valid = 1'b1; abort = 1'b1; din = 16'd8;
        #1;
        check("va_shift",     64'(shift),     64'd0);
        check("va_flush",     64'(flush),     64'd1);
        check("va_inp_ready", 64'(inp_ready), 64'd1);
        next_cyc();
        check("va_stay_idle", 64'(busy), 64'd0);
        inp_valid = 1'b0; abort = 1'b0;
        next_cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
